// File: rtl/silly_vector_sequencer.sv
// silly_vector_sequencer
//   On-chip self-test controller for the 3-input sillyfunction datapath.
//   On start it walks all 8 {a,b,c} vectors. Each vector is held for
//   SETTLE_CYCLES cycles, then y is checked against EXP_TT. The block
//   reports pass/fail, a saturating error count and the first failing vector.
//
//   state | meaning
//   IDLE  | outputs parked at 0, waiting for start
//   WAIT  | driving vector idx, settle down-counter running
//   CHECK | driving vector idx, y compared against EXP_TT[idx]
//   DONE  | one-cycle done pulse, pass is valid
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start             run request, accepted only in IDLE
//   a, b, c           stimulus to the sillyfunction ({a,b,c} = idx)
//   y                 sillyfunction output under check
//   busy, done        run in progress / end-of-run pulse
//   pass              last run had no mismatches
//   err_count         saturating mismatch count of the last run
//   fail_valid        fail_vec holds the first failing vector
//   fail_vec          index of the first failing vector
//
// Configuration macro: SILLY_STOP_ON_FAIL_EN
//   When defined, the first mismatch ends the run and skips the remaining
//   vectors. When undefined, all 8 vectors are always run.

module silly_vector_sequencer #(
  parameter logic [7:0] EXP_TT        = 8'h31,
  parameter int         SETTLE_CYCLES = 1,
  parameter int         ERRW          = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            a,
  output logic            b,
  output logic            c,
  input  logic            y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            fail_valid,
  output logic [2:0]      fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  // Settle counter counts down from SETTLE_CYCLES-1; terminal count 0
  // means the vector has been held for the full settle time.
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERRW-1:0] ERR_MAX     = '1;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      settle_q, settle_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] err_count_q, err_count_d;
  logic            fail_valid_q, fail_valid_d;
  logic [2:0]      fail_vec_q, fail_vec_d;
  logic            mismatch;
  logic            end_run;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    mismatch     = 1'b0;
    end_run      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_count_d  = '0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'd0;
          idx_d        = 3'd0;
          settle_d     = SETTLE_LOAD;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      S_CHECK: begin
        // Case inequality so an x or z on y is flagged as a mismatch.
        mismatch = (y !== EXP_TT[idx_q]);
        if (mismatch) begin
          if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + ERRW'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = idx_q;
          end
        end
`ifdef SILLY_STOP_ON_FAIL_EN
        end_run = mismatch || (idx_q == 3'd7);
`else
        end_run = (idx_q == 3'd7);
`endif
        if (end_run) begin
          // Use the updated count so pass is already valid during DONE.
          pass_d  = (err_count_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d    = idx_q + 3'd1;
          settle_d = SETTLE_LOAD;
          state_d  = S_WAIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      settle_q     <= 4'd0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign busy       = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign {a, b, c}  = busy ? idx_q : 3'd0;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
